tft_spi_decoder: RTL and testbench

TFT_SPI_DECODER -- requirements
Module: tft_spi_decoder

---
 rtl/tft_spi_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_tft_spi_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tft_spi_decoder.sv
// rtl/tft_spi_decoder.sv - SPI TFT command/pixel stream decoder (mode 0, MSB first).
// Optional TFT_SPI_DECODER_SYNC_EN adds a two-flop input synchronizer ahead of the sample stage.
module tft_spi_decoder #(
  parameter int COLS = 240,
  parameter int ROWS = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tft_clk,
  input  logic        tft_mosi,
  input  logic        tft_dc,
  input  logic        tft_cs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code
);

  localparam logic [8:0] XE_RST = 9'(COLS - 1);
  localparam logic [8:0] YE_RST = 9'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR_HI,
    S_RAMWR_LO
  } state_t;

  // Pin bundle order: {clk, mosi, dc, cs}; cs idles high so reset never looks selected.
  logic [3:0] pin_raw;

`ifdef TFT_SPI_DECODER_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b0001;
      sync2_q <= 4'b0001;
    end else begin
      sync1_q <= {tft_clk, tft_mosi, tft_dc, tft_cs};
      sync2_q <= sync1_q;
    end
  end
  assign pin_raw = sync2_q;
`else
  assign pin_raw = {tft_clk, tft_mosi, tft_dc, tft_cs};
`endif

  logic [3:0]  pin_q, pin_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_dc_q, byte_dc_d;

  state_t      state_q, state_d;
  logic [2:0]  par_cnt_q, par_cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_color_q, pix_color_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;

  logic sclk, smosi, sdc, scs, rise;
  assign sclk  = pin_q[3];
  assign smosi = pin_q[2];
  assign sdc   = pin_q[1];
  assign scs   = pin_q[0];
  assign rise  = !sclk_prev_q && sclk && !scs;

  always_comb begin
    pin_d        = pin_raw;
    sclk_prev_d  = sclk;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    if (scs) begin
      bit_cnt_d = 3'd0;
    end else if (rise) begin
      shift_d   = {shift_q[5:0], smosi};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, smosi};
        byte_dc_d    = sdc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    par_cnt_d   = par_cnt_q;
    hi_d        = hi_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    if (byte_valid_q) begin
      if (!byte_dc_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = byte_data_q;
        par_cnt_d   = 3'd0;
        case (byte_data_q)
          8'h2A:   state_d = S_CASET;
          8'h2B:   state_d = S_PASET;
          8'h2C: begin
            state_d = S_RAMWR_HI;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        case (state_q)
          S_CASET, S_PASET: begin
            // Even bytes are high halves; odd bytes complete a 9-bit window bound.
            if (par_cnt_q < 3'd4) begin
              par_cnt_d = par_cnt_q + 3'd1;
              case (par_cnt_q[1:0])
                2'd1: begin
                  if (state_q == S_CASET) xs_d = {hi_q[0], byte_data_q};
                  else                    ys_d = {hi_q[0], byte_data_q};
                end
                2'd3: begin
                  if (state_q == S_CASET) xe_d = {hi_q[0], byte_data_q};
                  else                    ye_d = {hi_q[0], byte_data_q};
                end
                default: hi_d = byte_data_q;
              endcase
            end
          end
          S_RAMWR_HI: begin
            hi_d    = byte_data_q;
            state_d = S_RAMWR_LO;
          end
          S_RAMWR_LO: begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_color_d = {hi_q, byte_data_q};
            state_d     = S_RAMWR_HI;
            if (x_q >= xe_q) begin
              x_d = xs_q;
              y_d = (y_q >= ye_q) ? ys_q : y_q + 9'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_q        <= 4'b0001;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_dc_q    <= 1'b0;
      state_q      <= S_IDLE;
      par_cnt_q    <= 3'd0;
      hi_q         <= 8'd0;
      xs_q         <= 9'd0;
      xe_q         <= XE_RST;
      ys_q         <= 9'd0;
      ye_q         <= YE_RST;
      x_q          <= 9'd0;
      y_q          <= 9'd0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 9'd0;
      pix_y_q      <= 9'd0;
      pix_color_q  <= 16'd0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'd0;
    end else begin
      pin_q        <= pin_d;
      sclk_prev_q  <= sclk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      state_q      <= state_d;
      par_cnt_q    <= par_cnt_d;
      hi_q         <= hi_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;

endmodule

// File: tb/tb_tft_spi_decoder.sv
// tb/tb_tft_spi_decoder.sv - directed plus randomized bench for tft_spi_decoder.
// Captured output events are scoreboarded against a byte-level reference model.
module tb_tft_spi_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tft_clk = 1'b0, tft_mosi = 1'b0, tft_dc = 1'b0, tft_cs = 1'b1;
  logic        byte_valid, byte_dc, pix_valid, cmd_valid;
  logic [7:0]  byte_data, cmd_code;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;

  int vectors = 0;
  int miscompares = 0;
  int overlap_cnt = 0;

  tft_spi_decoder dut (
    .clk(clk), .rst(rst), .tft_clk(tft_clk), .tft_mosi(tft_mosi), .tft_dc(tft_dc),
    .tft_cs(tft_cs), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code)
  );

  always #5 clk = ~clk;

  logic [8:0]  got_b[$], exp_b[$];
  logic [33:0] got_p[$], exp_p[$];
  logic [7:0]  got_c[$], exp_c[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) got_b.push_back({byte_dc, byte_data});
      if (pix_valid)  got_p.push_back({pix_x, pix_y, pix_color});
      if (cmd_valid)  got_c.push_back(cmd_code);
      if (pix_valid && cmd_valid) overlap_cnt++;
    end
  end

  // Reference model: byte-level interpretation of the command set.
  int         m_mode;   // 0 idle, 1 column window, 2 row window, 3 pixel high, 4 pixel low
  int         m_n;
  logic [7:0] m_buf [4];
  int         m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  logic [7:0] m_hi;

  task automatic model_reset();
    m_mode = 0; m_n = 0;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_x = 0; m_y = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    exp_b.push_back({dc, b});
    if (!dc) begin
      exp_c.push_back(b);
      m_n = 0;
      if (b == 8'h2A) m_mode = 1;
      else if (b == 8'h2B) m_mode = 2;
      else if (b == 8'h2C) begin m_mode = 3; m_x = m_xs; m_y = m_ys; end
      else m_mode = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_n < 4) begin
        m_buf[m_n] = b;
        if (m_n == 1 || m_n == 3) begin
          int v;
          v = ((m_buf[m_n-1] * 256) + b) % 512;
          if (m_mode == 1) begin if (m_n == 1) m_xs = v; else m_xe = v; end
          else             begin if (m_n == 1) m_ys = v; else m_ye = v; end
        end
        m_n++;
      end
    end else if (m_mode == 3) begin
      m_hi = b; m_mode = 4;
    end else if (m_mode == 4) begin
      exp_p.push_back({9'(m_x), 9'(m_y), m_hi, b});
      if (m_x >= m_xe) begin
        m_x = m_xs;
        m_y = (m_y >= m_ye) ? m_ys : m_y + 1;
      end else m_x = m_x + 1;
      m_mode = 3;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    tft_cs = 1'b0;
    tft_dc = dc;
    for (int i = 0; i < n; i++) begin
      tft_mosi = b[7-i];
      repeat (3) @(posedge clk);
      tft_clk = 1'b1;
      repeat (3) @(posedge clk);
      tft_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
    model_byte(b, dc);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all(input string tag);
    int n;
    repeat (20) @(posedge clk);
    chk({tag, "_nbytes"}, got_b.size(), exp_b.size());
    chk({tag, "_npix"}, got_p.size(), exp_p.size());
    chk({tag, "_ncmd"}, got_c.size(), exp_c.size());
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_b[i], exp_b[i]);
    n = (got_p.size() < exp_p.size()) ? got_p.size() : exp_p.size();
    for (int i = 0; i < n; i++) chk({tag, "_pix"}, got_p[i], exp_p[i]);
    n = (got_c.size() < exp_c.size()) ? got_c.size() : exp_c.size();
    for (int i = 0; i < n; i++) chk({tag, "_cmd"}, got_c[i], exp_c[i]);
    got_b.delete(); exp_b.delete();
    got_p.delete(); exp_p.delete();
    got_c.delete(); exp_c.delete();
  endtask

  task automatic do_reset();
    tft_clk = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_outputs", {byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_color, cmd_valid, cmd_code}, '0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  task automatic set_window(input int xs, input int xe, input int ys, input int ye);
    send_byte(8'h2A, 1'b0);
    send_byte(8'(xs >> 8), 1'b1); send_byte(8'(xs), 1'b1);
    send_byte(8'(xe >> 8), 1'b1); send_byte(8'(xe), 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'(ys >> 8), 1'b1); send_byte(8'(ys), 1'b1);
    send_byte(8'(ye >> 8), 1'b1); send_byte(8'(ye), 1'b1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single command byte.
    send_byte(8'hA5, 1'b0);
    check_all("cmd_a5");

    // Window 10..12 x 5..6, 6 pixels.
    set_window(10, 12, 5, 6);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(8'(i * 17 + 3), 1'b1);
    check_all("win_6pix");
    chk("win_last_x", pix_x, 9'd12);
    chk("win_last_y", pix_y, 9'd6);

    // From reset window: two colors at (0,0) and (1,0).
    do_reset();
    send_byte(8'h2C, 1'b0);
    send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
    check_all("colors");

    // Row wrap in 2x1 window.
    set_window(0, 1, 0, 0);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    check_all("row_wrap");

    // Command in RAMWR_LO drops the high byte; following data in IDLE is ignored.
    send_byte(8'h2C, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    check_all("abort_lo");

    // Chip-select abort after 5 bits.
    send_bits(8'hFF, 5, 1'b1);
    tft_cs = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'h3C, 1'b0);
    check_all("cs_abort");

    // Reset pulse after 3 bits.
    send_bits(8'hFF, 3, 1'b1);
    do_reset();
    send_byte(8'h3C, 1'b0);
    check_all("rst_abort");

    // Randomized windows, extra window bytes, stray commands and pixel bursts.
    for (int t = 0; t < 4; t++) begin
      int xs, ys, np;
      xs = $urandom_range(0, 300);
      ys = $urandom_range(0, 300);
      set_window(xs, xs + $urandom_range(0, 3), ys, ys + $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) send_byte(8'h55, 1'b0);
      send_byte(8'h2C, 1'b0);
      np = $urandom_range(1, 8);
      for (int i = 0; i < 2 * np; i++) send_byte(8'($urandom), 1'b1);
      check_all("random");
    end

    chk("pix_cmd_overlap", overlap_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
